// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths,
// control-bit positions inside the memory and write-back control fields,
// and the packed payload layout carried from EX to MEM.
package ex_mem_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RA_W_DEF   = 5;
    localparam int unsigned WB_W_DEF   = 2;
    localparam int unsigned MEM_W_DEF  = 2;

    // Bit positions inside mem control and wb control
    localparam int unsigned MEM_WRITE_BIT = 1;
    localparam int unsigned MEM_READ_BIT  = 0;
    localparam int unsigned REG_WRITE_BIT = 0;

    // Payload at default widths; field order matches the packing in ex_mem_pipe
    typedef struct packed {
        logic [WB_W_DEF-1:0]   wb;
        logic [MEM_W_DEF-1:0]  mem;
        logic [DATA_W_DEF-1:0] alu;
        logic [DATA_W_DEF-1:0] wdata;
        logic [RA_W_DEF-1:0]   rd;
    } ex_mem_payload_t;

    localparam int unsigned PAYLOAD_W_DEF = $bits(ex_mem_payload_t);

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer (main + skid) with a fully registered in_ready.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   flush             drop everything held plus the same-cycle input
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
module skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid, main_valid_d;
    logic         skid_valid, skid_valid_d;
    logic         ready_q, ready_d;
    logic [W-1:0] main_data, main_data_d;
    logic [W-1:0] skid_data, skid_data_d;

    logic accept;
    logic drain;
    logic main_free;

    // ready_q is registered so out_ready never reaches in_ready combinationally
    assign accept    = in_valid & ready_q & ~flush;
    assign drain     = main_valid & out_ready;
    assign main_free = ~main_valid | drain;

    // Next-state for both entries; payloads only change when an entry loads
    always_comb begin
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        main_data_d  = main_data;
        skid_data_d  = skid_data;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = in_data;
                end
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // main is stalled, so the accepted word parks in the skid entry
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end

        ready_d = ~skid_valid_d;
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
            main_data  <= '0;
            skid_data  <= '0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            ready_q    <= ready_d;
            main_data  <= main_data_d;
            skid_data  <= skid_data_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register built on a skid buffer, with bubble gating of
// side-effecting controls and a forwarding tap for EX operand bypass.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   in_valid/in_ready              EX-side handshake
//   wb_in, mem_in, alu_in, wdata_in, rd_in   EX payload
//   flush                          discard held and incoming instructions
//   out_valid/out_ready            MEM-side handshake
//   wb_out, mem_we, mem_re, alu_out, wdata_out, rd_out   MEM payload
//   fwd_en, fwd_rd, fwd_data       forwarding tap
module ex_mem_pipe
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RA_W   = RA_W_DEF,
    parameter int unsigned WB_W   = WB_W_DEF,
    parameter int unsigned MEM_W  = MEM_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [MEM_W-1:0]  mem_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [RA_W-1:0]   rd_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   wb_out,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] wdata_out,
    output logic [RA_W-1:0]   rd_out,
    output logic              fwd_en,
    output logic [RA_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int unsigned PAYLOAD_W = WB_W + MEM_W + 2 * DATA_W + RA_W;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 held_valid;
    logic [WB_W-1:0]      wb_q;
    logic [MEM_W-1:0]     mem_q;

    assign in_payload = {wb_in, mem_in, alu_in, wdata_in, rd_in};

    skid_buffer #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (held_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {wb_q, mem_q, alu_out, wdata_out, rd_out} = out_payload;

    // Payload registers keep stale values after drain/flush, so controls
    // with side effects are masked to make a bubble harmless
    assign out_valid = held_valid;
    assign wb_out    = held_valid ? wb_q : '0;
    assign mem_we    = held_valid & mem_q[MEM_WRITE_BIT];
    assign mem_re    = held_valid & mem_q[MEM_READ_BIT];

    // x0 is hardwired zero, so writes to it are never forwarded
    assign fwd_en   = held_valid & wb_q[REG_WRITE_BIT] & (rd_out != '0);
    assign fwd_rd   = rd_out;
    assign fwd_data = alu_out;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: a two-deep FIFO reference model checked against
// the DUT every cycle, plus directed scenarios with literal expectations.
module tb_ex_mem_pipe;
    import ex_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_in;
    logic [1:0]  mem_in;
    logic [31:0] alu_in;
    logic [31:0] wdata_in;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  wb_out;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] alu_out;
    logic [31:0] wdata_out;
    logic [4:0]  rd_out;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    ex_mem_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wb_in     (wb_in),
        .mem_in    (mem_in),
        .alu_in    (alu_in),
        .wdata_in  (wdata_in),
        .rd_in     (rd_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_out    (wb_out),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .alu_out   (alu_out),
        .wdata_out (wdata_out),
        .rd_out    (rd_out),
        .fwd_en    (fwd_en),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue holding at most two instructions
    ex_mem_payload_t mq[$];
    ex_mem_payload_t in_pl;
    bit              m_acc;

    assign in_pl = '{wb: wb_in, mem: mem_in, alu: alu_in, wdata: wdata_in, rd: rd_in};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            m_acc = in_valid && (mq.size() < 2);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (m_acc) mq.push_back(in_pl);
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    ex_mem_payload_t e;
    always @(negedge clk) begin
        if (reset === 1'b1 && cmp_en) begin
            check("m_in_ready", 32'(in_ready), 32'(mq.size() < 2));
            check("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                e = mq[0];
                check("m_wb_out", 32'(wb_out), 32'(e.wb));
                check("m_mem_we", 32'(mem_we), 32'(e.mem[1]));
                check("m_mem_re", 32'(mem_re), 32'(e.mem[0]));
                check("m_alu_out", alu_out, e.alu);
                check("m_wdata_out", wdata_out, e.wdata);
                check("m_rd_out", 32'(rd_out), 32'(e.rd));
                check("m_fwd_en", 32'(fwd_en), 32'(e.wb[0] && e.rd != 5'd0));
                check("m_fwd_rd", 32'(fwd_rd), 32'(e.rd));
                check("m_fwd_data", fwd_data, e.alu);
            end else begin
                check("m_bubble_ctl", {27'd0, wb_out, mem_we, mem_re, fwd_en}, 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic ex_mem_payload_t mk(input logic [1:0] wb, input logic [1:0] mem,
                                           input logic [31:0] alu, input logic [31:0] wd,
                                           input logic [4:0] rd);
        mk = '{wb: wb, mem: mem, alu: alu, wdata: wd, rd: rd};
    endfunction

    task automatic drive(input ex_mem_payload_t p);
        wb_in    = p.wb;
        mem_in   = p.mem;
        alu_in   = p.alu;
        wdata_in = p.wdata;
        rd_in    = p.rd;
        in_valid = 1'b1;
    endtask

    // Hold the instruction until an edge sees in_ready high
    task automatic send(input ex_mem_payload_t p);
        logic rdy;
        int   n;
        drive(p);
        n = 0;
        do begin
            rdy = in_ready;
            cyc();
            n++;
        end while (!rdy && n < 50);
        check("send_accept", 32'(rdy), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        ex_mem_payload_t rp;
        logic rdy;
        bit   pending;
        int   seq;

        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb_in = '0; mem_in = '0; alu_in = '0; wdata_in = '0; rd_in = '0;
        cmp_en = 1;
        repeat (3) cyc();

        // Reset values
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_out", alu_out, 32'd0);
        check("rst_wdata_out", wdata_out, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        reset = 1'b1;

        // Single ALU write to r5, latency one cycle
        out_ready = 1'b1;
        drive(mk(2'b01, 2'b00, 32'h0000_1234, 32'h0, 5'd5));
        cyc();
        in_valid = 1'b0;
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_alu_out", alu_out, 32'h0000_1234);
        check("lat_fwd_en", 32'(fwd_en), 32'd1);
        check("lat_fwd_rd", 32'(fwd_rd), 32'd5);
        cyc();
        check("lat_drained", 32'(out_valid), 32'd0);

        // Back-pressure: A in main, B in skid, C waits
        out_ready = 1'b0;
        send(mk(2'b01, 2'b00, 32'hA, 32'h0, 5'd1));
        send(mk(2'b01, 2'b00, 32'hB, 32'h0, 5'd2));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_main_A", alu_out, 32'hA);
        drive(mk(2'b01, 2'b00, 32'hC, 32'h0, 5'd3));
        cyc();
        cyc();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_A", alu_out, 32'hA);
        out_ready = 1'b1;
        cyc();
        check("bp_out_B", alu_out, 32'hB);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("bp_out_C", alu_out, 32'hC);
        check("bp_C_valid", 32'(out_valid), 32'd1);
        cyc();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush with both entries full and a new instruction offered
        out_ready = 1'b0;
        send(mk(2'b01, 2'b10, 32'hE, 32'h1111, 5'd3));
        send(mk(2'b01, 2'b01, 32'hF, 32'h2222, 5'd4));
        check("fl_pre_we", 32'(mem_we), 32'd1);
        drive(mk(2'b01, 2'b10, 32'h6, 32'h3333, 5'd6));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_mem_we", 32'(mem_we), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            cyc();
            check("fl_nothing", 32'(out_valid), 32'd0);
        end

        // Store to rd=0: mem_we only while valid, never forwarded
        out_ready = 1'b0;
        drive(mk(2'b01, 2'b10, 32'h77, 32'hDEAD_BEEF, 5'd0));
        cyc();
        in_valid = 1'b0;
        check("st_valid", 32'(out_valid), 32'd1);
        check("st_mem_we", 32'(mem_we), 32'd1);
        check("st_wdata", wdata_out, 32'hDEAD_BEEF);
        check("st_fwd_en", 32'(fwd_en), 32'd0);
        cyc();
        check("st_mem_we_hold", 32'(mem_we), 32'd1);
        out_ready = 1'b1;
        cyc();
        check("st_done_valid", 32'(out_valid), 32'd0);
        check("st_done_we", 32'(mem_we), 32'd0);

        // Asynchronous reset mid-cycle with both entries full
        out_ready = 1'b0;
        send(mk(2'b01, 2'b11, 32'h88, 32'h99, 5'd7));
        send(mk(2'b01, 2'b10, 32'h89, 32'h9A, 5'd8));
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_ctl", {27'd0, wb_out, mem_we, mem_re, fwd_en}, 32'd0);
        check("ar_alu", alu_out, 32'd0);
        check("ar_wdata", wdata_out, 32'd0);
        check("ar_rd", 32'(rd_out), 32'd0);
        check("ar_fwd_data", fwd_data, 32'd0);
        cyc();
        reset = 1'b1;
        out_ready = 1'b1;
        send(mk(2'b01, 2'b00, 32'h5A, 32'h0, 5'd9));
        check("ar_first_accept", alu_out, 32'h5A);
        check("ar_first_valid", 32'(out_valid), 32'd1);
        cyc();

        // Random traffic; the per-cycle model compare covers order and loss
        pending = 0;
        seq = 32'h100;
        rp = mk(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 10000; i++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                rp = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        32'(seq), $urandom, 5'($urandom_range(0, 31)));
                seq++;
                pending = 1;
            end
            drive(rp);
            in_valid  = pending;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            rdy = in_ready;
            cyc();
            if (pending && (flush || rdy)) pending = 0;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        check("end_empty", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
